// File: rtl/spart_echo_driver_if.sv
// SPART control/handshake bundle. databus stays a plain inout on the driver so the
// tristate resolves on a single net at the level that instantiates both ends.
interface spart_echo_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_echo_driver.sv
// SPART host driver: programs the baud divisor from a rate table, then echoes received
// bytes through a FIFO with an optional ASCII case transform and sticky overrun flag.
module spart_echo_driver #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD0      = 4800,
  parameter int unsigned BAUD1      = 9600,
  parameter int unsigned BAUD2      = 19200,
  parameter int unsigned BAUD3      = 38400,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    i_br_cfg,
  input  logic [1:0]                    i_case_mode,
  spart_echo_driver_if.master           bus,
  inout  wire  [7:0]                    io_databus,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overrun
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DIV0  = CLK_HZ / (16 * BAUD0) - 1;
  localparam int unsigned DIV1  = CLK_HZ / (16 * BAUD1) - 1;
  localparam int unsigned DIV2  = CLK_HZ / (16 * BAUD2) - 1;
  localparam int unsigned DIV3  = CLK_HZ / (16 * BAUD3) - 1;
  localparam logic [LW-1:0] LvlFull = LW'(FIFO_DEPTH);

  if (DIV0 > 32'hFFFF || DIV1 > 32'hFFFF || DIV2 > 32'hFFFF || DIV3 > 32'hFFFF) begin : g_div_chk
    $error("spart_echo_driver: baud divisor does not fit in 16 bits");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("spart_echo_driver: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {StInitLo, StInitHi, StIdle, StRd, StWr, StGap} state_e;
  typedef logic [AW-1:0] ptr_t;

  function automatic logic [15:0] div_of(input logic [1:0] cfg);
    case (cfg)
      2'd0: div_of = 16'(DIV0);
      2'd1: div_of = 16'(DIV1);
      2'd2: div_of = 16'(DIV2);
      2'd3: div_of = 16'(DIV3);
    endcase
  endfunction

  function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] mode);
    logic is_up;
    logic is_lo;
    is_up = (b >= 8'h41) && (b <= 8'h5A);
    is_lo = (b >= 8'h61) && (b <= 8'h7A);
    xform = b;
    case (mode)
      2'b01:   if (is_lo) xform = b - 8'h20;
      2'b10:   if (is_up) xform = b + 8'h20;
      2'b11:   if (is_lo || is_up) xform = b ^ 8'h20;
      default: xform = b;
    endcase
  endfunction

  state_e          r_state, w_state_nxt;
  logic            r_armed;
  logic [1:0]      r_br_q, r_applied;
  logic            r_cfg_pending;
  logic [15:0]     r_div;
  logic [7:0]      r_mem [FIFO_DEPTH];
  ptr_t            r_wptr, r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_overrun;

  logic            w_iocs, w_iorw, w_drive;
  logic [1:0]      w_ioaddr;
  logic [7:0]      w_dout;
  logic            w_enter_init, w_push, w_pop, w_full;

  assign w_full       = (r_level == LvlFull);
  assign w_enter_init = (r_state == StIdle) && (w_state_nxt == StInitLo);
  assign w_push       = (r_state == StRd) && !w_full;
  assign w_pop        = (r_state == StWr);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StInitLo: if (!r_armed) w_state_nxt = StInitHi;
      StInitHi: w_state_nxt = StGap;
      StIdle: begin
        if (r_cfg_pending && r_level == '0)     w_state_nxt = StInitLo;
        else if (bus.rda)                       w_state_nxt = StRd;
        else if (bus.tbr && r_level != '0)      w_state_nxt = StWr;
      end
      StRd, StWr: w_state_nxt = StGap;
      StGap:      w_state_nxt = StIdle;
      default:    w_state_nxt = StIdle;
    endcase
  end

  // r_armed holds the bus quiet for the reset cycle before the first INIT_LO strobe.
  always_comb begin
    w_iocs   = 1'b0;
    w_iorw   = 1'b1;
    w_ioaddr = 2'b00;
    w_drive  = 1'b0;
    w_dout   = 8'h00;
    if (!r_armed) begin
      unique case (r_state)
        StInitLo: begin
          w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b10; w_drive = 1'b1; w_dout = r_div[7:0];
        end
        StInitHi: begin
          w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b11; w_drive = 1'b1; w_dout = r_div[15:8];
        end
        StRd: w_iocs = 1'b1;
        StWr: begin
          w_iocs = 1'b1; w_iorw = 1'b0; w_drive = 1'b1; w_dout = r_mem[r_rptr];
        end
        default: w_iocs = 1'b0;
      endcase
    end
  end

  assign bus.iocs   = w_iocs;
  assign bus.iorw   = w_iorw;
  assign bus.ioaddr = w_ioaddr;
  assign io_databus = w_drive ? w_dout : 8'hzz;
  assign o_level    = r_level;
  assign o_overrun  = r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInitLo;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b0;
    end
  end

  // A mismatch is latched, so a glitch that reverts still costs one re-program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_q        <= 2'b00;
      r_applied     <= 2'b00;
      r_cfg_pending <= 1'b0;
      r_div         <= 16'h0000;
    end else begin
      r_br_q <= i_br_cfg;
      if (r_armed) begin
        r_applied <= i_br_cfg;
        r_div     <= div_of(i_br_cfg);
      end else if (w_enter_init) begin
        r_applied     <= r_br_q;
        r_div         <= div_of(r_br_q);
        r_cfg_pending <= 1'b0;
      end else if (r_br_q != r_applied) begin
        r_cfg_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= xform(io_databus, i_case_mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ptr_t'(1);
      if (w_pop)  r_rptr <= r_rptr + ptr_t'(1);
      if (w_push)     r_level <= r_level + LW'(1);
      else if (w_pop) r_level <= r_level - LW'(1);
      if (r_state == StRd && w_full) r_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: SPART-side model feeds rx bytes and logs every bus access;
// expectations come from the divisor formula and an ASCII case model.
module tb_spart_echo_driver;
  localparam int unsigned ClkHz = 100_000_000;
  localparam int unsigned Depth = 8;
  localparam int unsigned LW    = $clog2(Depth) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    br_cfg = 2'b01;
  logic [1:0]    case_mode = 2'b00;
  logic          tbr = 1'b0;
  wire  [7:0]    databus;
  logic [LW-1:0] level;
  logic          overrun;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  rx_mem [0:4095];
  int          rx_wr = 0;
  int          rx_rd = 0;
  logic [10:0] elog [0:4095];  // {is_read, ioaddr, data}
  int          ecnt = 0;

  spart_echo_driver_if bus ();

  assign bus.rda = (rx_wr != rx_rd);
  assign bus.tbr = tbr;
  assign databus = (bus.iocs && bus.iorw) ? rx_mem[rx_rd] : 8'hzz;

  spart_echo_driver #(
    .CLK_HZ(ClkHz), .BAUD0(4800), .BAUD1(9600), .BAUD2(19200), .BAUD3(38400),
    .FIFO_DEPTH(Depth)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_br_cfg(br_cfg), .i_case_mode(case_mode), .bus(bus),
    .io_databus(databus), .o_level(level), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.iocs) begin
      elog[ecnt] <= {bus.iorw, bus.ioaddr, databus};
      ecnt <= ecnt + 1;
      if (bus.iorw) rx_rd <= rx_rd + 1;
    end
  end

  function automatic logic [15:0] div_of(input int cfg);
    int baud;
    baud = (cfg == 0) ? 4800 : (cfg == 1) ? 9600 : (cfg == 2) ? 19200 : 38400;
    return 16'(ClkHz / (16 * baud) - 1);
  endfunction

  function automatic logic [7:0] ref_case(input logic [7:0] b, input logic [1:0] mode);
    int c;
    c = int'(b);
    if ((mode == 2'd1 || mode == 2'd3) && c >= 97 && c <= 122) return 8'(c - 32);
    if ((mode == 2'd2 || mode == 2'd3) && c >= 65 && c <= 90) return 8'(c + 32);
    return b;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic wait_log(input int target, input int budget, output bit ok);
    int k;
    k = 0;
    while (ecnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (ecnt >= target);
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    int k;
    k = 0;
    while (rx_rd != rx_wr && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (rx_rd == rx_wr);
  endtask

  task automatic test_reset;
    logic [15:0] d;
    rst_n = 1'b0; br_cfg = 2'b01; tbr = 1'b0; case_mode = 2'b00;
    wait_cycles(2);
    tests_run++;
    if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_bus: got %b want 0100", {bus.iocs, bus.iorw, bus.ioaddr});
    end
    tests_run++;
    if (databus !== 8'hzz && databus !== 8'h00) begin
      tests_failed++; $display("FAIL reset_databus: got %h want z", databus);
    end
    tests_run++;
    if (level !== '0 || overrun !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state: level %0d overrun %b want 0 0", level, overrun);
    end
    rst_n = 1'b1;
    d = div_of(1);
    @(negedge clk);
    tests_run++;
    if ({bus.iocs, bus.iorw, bus.ioaddr, databus} !== {1'b1, 1'b0, 2'b10, d[7:0]}) begin
      tests_failed++;
      $display("FAIL init_lo: got %b %b %b %h want 1 0 10 %h",
               bus.iocs, bus.iorw, bus.ioaddr, databus, d[7:0]);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.iocs, bus.iorw, bus.ioaddr, databus} !== {1'b1, 1'b0, 2'b11, d[15:8]}) begin
      tests_failed++;
      $display("FAIL init_hi: got %b %b %b %h want 1 0 11 %h",
               bus.iocs, bus.iorw, bus.ioaddr, databus, d[15:8]);
    end
    @(negedge clk);
    tests_run++;
    if (bus.iocs !== 1'b0 || (databus !== 8'hzz && databus !== 8'h00)) begin
      tests_failed++; $display("FAIL init_gap: iocs %b databus %h want 0 z", bus.iocs, databus);
    end
    wait_cycles(3);
  endtask

  task automatic test_case_echo;
    int base;
    bit ok;
    case_mode = 2'b01; tbr = 1'b1; base = ecnt;
    push_rx(8'h61);
    @(negedge clk);
    tests_run++;
    if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL echo_rd_strobe: got %b want 1100", {bus.iocs, bus.iorw, bus.ioaddr});
    end
    @(negedge clk);
    tests_run++;
    if (level !== LW'(1)) begin
      tests_failed++; $display("FAIL echo_level1: got %0d want 1", level);
    end
    wait_log(base + 2, 30, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL echo_timeout: got %0d accesses want 2", ecnt - base);
    end
    tests_run++;
    if (elog[base + 1] !== {1'b0, 2'b00, ref_case(8'h61, 2'b01)}) begin
      tests_failed++; $display("FAIL echo_wr: got %h want %h", elog[base + 1],
                               {1'b0, 2'b00, ref_case(8'h61, 2'b01)});
    end
    tests_run++;
    if (level !== '0) begin
      tests_failed++; $display("FAIL echo_level0: got %0d want 0", level);
    end
    tbr = 1'b0; case_mode = 2'b00;
    wait_cycles(2);
  endtask

  task automatic test_overrun;
    logic [7:0] b [0:15];
    int base;
    bit ok;
    tbr = 1'b0; case_mode = 2'b00; base = ecnt;
    for (int i = 0; i < Depth + 1; i++) begin
      b[i] = 8'($urandom);
      push_rx(b[i]);
    end
    for (int k = 0; k < 100 && rx_rd < rx_wr - 1; k++) @(negedge clk);
    tests_run++;
    if (level !== LW'(Depth) || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_full: level %0d overrun %b want %0d 0", level, overrun, Depth);
    end
    wait_drained(100, ok);
    tests_run++;
    if (!ok || level !== LW'(Depth) || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_set: level %0d overrun %b want %0d 1", level, overrun, Depth);
    end
    tbr = 1'b1;
    wait_log(base + 2 * Depth + 1, 200, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL ovr_drain_timeout: got %0d accesses", ecnt - base);
    end
    for (int i = 0; i < Depth; i++) begin
      tests_run++;
      if (elog[base + Depth + 1 + i] !== {1'b0, 2'b00, b[i]}) begin
        tests_failed++;
        $display("FAIL ovr_order[%0d]: got %h want %h", i, elog[base + Depth + 1 + i],
                 {1'b0, 2'b00, b[i]});
      end
    end
    tests_run++;
    if (level !== '0 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_sticky: level %0d overrun %b want 0 1", level, overrun);
    end
    tbr = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_random_bursts;
    logic [7:0] b [0:15];
    logic [1:0] cm;
    int n, base;
    bit ok;
    for (int r = 0; r < 6; r++) begin
      cm = 2'($urandom_range(0, 3));
      case_mode = cm;
      n = $urandom_range(1, Depth);
      base = ecnt; tbr = 1'b0;
      for (int i = 0; i < n; i++) begin
        b[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h40, 8'h7B)) : 8'($urandom);
        push_rx(b[i]);
      end
      wait_drained(200, ok);
      tests_run++;
      if (!ok || level !== LW'(n)) begin
        tests_failed++; $display("FAIL burst%0d_level: got %0d want %0d", r, level, n);
      end
      tbr = 1'b1;
      wait_log(base + 2 * n, 200, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++; $display("FAIL burst%0d_timeout: got %0d accesses", r, ecnt - base);
      end
      for (int i = 0; i < n; i++) begin
        tests_run++;
        if (elog[base + n + i] !== {1'b0, 2'b00, ref_case(b[i], cm)}) begin
          tests_failed++;
          $display("FAIL burst%0d[%0d] mode %0d in %h: got %h want %h", r, i, cm, b[i],
                   elog[base + n + i], {1'b0, 2'b00, ref_case(b[i], cm)});
        end
      end
      tbr = 1'b0;
      wait_cycles(2);
    end
    case_mode = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [0:2];
    int base;
    bit ok;
    tbr = 1'b0; case_mode = 2'b00;
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    push_rx(b[0]);
    push_rx(b[1]);
    wait_drained(50, ok);
    tests_run++;
    if (!ok || level !== LW'(2)) begin
      tests_failed++; $display("FAIL b2b_level: got %0d want 2", level);
    end
    base = ecnt;
    push_rx(b[2]);
    tbr = 1'b1;
    wait_log(base + 4, 100, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL b2b_timeout: got %0d accesses want 4", ecnt - base);
    end
    tests_run++;
    if (elog[base] !== {1'b1, 2'b00, b[2]}) begin
      tests_failed++; $display("FAIL b2b_rd_first: got %h want %h", elog[base], {1'b1, 2'b00, b[2]});
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (elog[base + 1 + i] !== {1'b0, 2'b00, b[i]}) begin
        tests_failed++;
        $display("FAIL b2b_wr[%0d]: got %h want %h", i, elog[base + 1 + i], {1'b0, 2'b00, b[i]});
      end
    end
    tbr = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reconfig;
    logic [7:0] b [0:2];
    logic [15:0] d;
    int base;
    bit ok;
    tbr = 1'b0; base = ecnt;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      push_rx(b[i]);
    end
    wait_drained(50, ok);
    tests_run++;
    if (!ok || level !== LW'(3)) begin
      tests_failed++; $display("FAIL cfg_level: got %0d want 3", level);
    end
    br_cfg = 2'b11;
    wait_cycles(3);
    tbr = 1'b1;
    wait_log(base + 8, 100, ok);
    d = div_of(3);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL cfg_timeout: got %0d accesses want 8", ecnt - base);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (elog[base + 3 + i] !== {1'b0, 2'b00, b[i]}) begin
        tests_failed++;
        $display("FAIL cfg_drain[%0d]: got %h want %h", i, elog[base + 3 + i], {1'b0, 2'b00, b[i]});
      end
    end
    tests_run++;
    if (elog[base + 6] !== {1'b0, 2'b10, d[7:0]} || elog[base + 7] !== {1'b0, 2'b11, d[15:8]}) begin
      tests_failed++;
      $display("FAIL cfg_div: got %h %h want %h %h", elog[base + 6], elog[base + 7],
               {1'b0, 2'b10, d[7:0]}, {1'b0, 2'b11, d[15:8]});
    end
    wait_cycles(10);
    tests_run++;
    if (ecnt !== base + 8) begin
      tests_failed++; $display("FAIL cfg_once: got %0d accesses want 8", ecnt - base);
    end
    base = ecnt;
    br_cfg = 2'b01;
    @(negedge clk);
    br_cfg = 2'b11;
    wait_log(base + 2, 50, ok);
    wait_cycles(10);
    tests_run++;
    if (!ok || ecnt !== base + 2) begin
      tests_failed++; $display("FAIL glitch_count: got %0d accesses want 2", ecnt - base);
    end
    tests_run++;
    if (elog[base] !== {1'b0, 2'b10, d[7:0]} || elog[base + 1] !== {1'b0, 2'b11, d[15:8]}) begin
      tests_failed++;
      $display("FAIL glitch_div: got %h %h want %h %h", elog[base], elog[base + 1],
               {1'b0, 2'b10, d[7:0]}, {1'b0, 2'b11, d[15:8]});
    end
    tbr = 1'b0;
  endtask

  task automatic test_reset_mid_wr;
    logic [15:0] d;
    bit ok;
    tbr = 1'b0;
    for (int i = 0; i < Depth + 1; i++) push_rx(8'($urandom));
    wait_drained(100, ok);
    tests_run++;
    if (!ok || overrun !== 1'b1) begin
      tests_failed++; $display("FAIL rstwr_prep: overrun %b want 1", overrun);
    end
    tbr = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.iocs && !bus.iorw;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL rstwr_no_wr: got no write cycle want one");
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.iocs !== 1'b0 || (databus !== 8'hzz && databus !== 8'h00)) begin
      tests_failed++; $display("FAIL rstwr_abort: iocs %b databus %h want 0 z", bus.iocs, databus);
    end
    tests_run++;
    if (level !== '0 || overrun !== 1'b0) begin
      tests_failed++; $display("FAIL rstwr_clear: level %0d overrun %b want 0 0", level, overrun);
    end
    br_cfg = 2'b00; tbr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d = div_of(0);
    @(negedge clk);
    tests_run++;
    if ({bus.iocs, bus.iorw, bus.ioaddr, databus} !== {1'b1, 1'b0, 2'b10, d[7:0]} ||
        level !== '0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstwr_init_lo: got %b %b %h lvl %0d ovr %b want 1 10 %h 0 0",
               bus.iocs, bus.ioaddr, databus, level, overrun, d[7:0]);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.iocs, bus.iorw, bus.ioaddr, databus} !== {1'b1, 1'b0, 2'b11, d[15:8]}) begin
      tests_failed++;
      $display("FAIL rstwr_init_hi: got %b %b %h want 1 11 %h", bus.iocs, bus.ioaddr, databus,
               d[15:8]);
    end
    wait_cycles(3);
  endtask

  initial begin
    test_reset();
    test_case_echo();
    test_overrun();
    test_random_bursts();
    test_back_to_back();
    test_reconfig();
    test_reset_mid_wr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
